// File: rtl/ram_sdp_sweep_clear.sv
// Simple dual-port RAM (one write port, one read port) with lane write enables and a sweep clear.
// Latency: registered read, q and q_valid one cycle after an accepted read; a clear sweep takes 2**ADDR_WIDTH cycles.
// Backpressure: while busy, or in the cycle clear_req is high, user reads and writes are dropped, not queued.
module ram_sdp_sweep_clear #(
   parameter int DATA_WIDTH     = 4,
   parameter int ADDR_WIDTH     = 7,
   parameter int LANES          = 1,
   parameter int RDW_MODE       = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                  clk,
   input  logic                  sync_clear,
   input  logic                  clear_req,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic [ADDR_WIDTH-1:0] write_addr,
   input  logic                  we,
   input  logic [LANES-1:0]      lane_we,
   input  logic [ADDR_WIDTH-1:0] read_addr,
   input  logic                  re,
   output logic [DATA_WIDTH-1:0] q,
   output logic                  q_valid,
   output logic                  busy
);

   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam int LW    = DATA_WIDTH / LANES;

   typedef enum logic {IDLE, SWEEP} state_t;

   state_t                  state, state_nxt;
   logic [ADDR_WIDTH-1:0]   ptr, ptr_nxt;
   logic                    accept;
   logic                    user_wr;
   logic                    user_rd;
   logic [DATA_WIDTH-1:0]   rd_word;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   assign busy    = (state == SWEEP);
   // A clear request steals its own cycle so the first sweep write never races a user write.
   assign accept  = ~busy & ~clear_req;
   assign user_wr = we & accept;
   assign user_rd = re & accept;

   // Next state and sweep pointer: start from address 0, leave after zeroing the last word.
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      case (state)
         IDLE: begin
            if (clear_req) begin
               state_nxt = SWEEP;
               ptr_nxt   = '0;
            end
         end
         SWEEP: begin
            ptr_nxt = ptr + 1'b1;
            if (&ptr) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
            ptr_nxt   = '0;
         end
      endcase
   end

   // State register; reset either (re)starts the sweep from word 0 or just parks the FSM.
   always_ff @(posedge clk) begin
      if (sync_clear) begin
         state <= (CLEAR_ON_RESET != 0) ? SWEEP : IDLE;
         ptr   <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
      end
   end

   // Read word, with written lanes forwarded on a same-address collision when new-data mode is chosen.
   always_comb begin
      rd_word = mem[read_addr];
      if ((RDW_MODE != 0) && user_wr && (write_addr == read_addr)) begin
         for (int i = 0; i < LANES; i++) begin
            if (lane_we[i]) begin
               rd_word[i*LW +: LW] = data[i*LW +: LW];
            end
         end
      end
   end

   // Array writes: sweep zeroing or masked user write; nothing is written while reset is held.
   always_ff @(posedge clk) begin
      if (!sync_clear) begin
         if (busy) begin
            mem[ptr] <= '0;
         end else if (user_wr) begin
            for (int i = 0; i < LANES; i++) begin
               if (lane_we[i]) begin
                  mem[write_addr][i*LW +: LW] <= data[i*LW +: LW];
               end
            end
         end
      end
   end

   // Registered read port; q holds its value between accepted reads.
   always_ff @(posedge clk) begin
      if (sync_clear) begin
         q       <= '0;
         q_valid <= 1'b0;
      end else begin
         q_valid <= user_rd;
         if (user_rd) begin
            q <= rd_word;
         end
      end
   end

endmodule

// File: doc/ram_sdp_sweep_clear.md
RAM_SDP_SWEEP_CLEAR -- requirements
Module: ram_sdp_sweep_clear

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4: word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 7: address width; DEPTH = 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter LANES, default 1: write-enable lanes; DATA_WIDTH % LANES == 0; LW = DATA_WIDTH/LANES.
REQ-004 SHALL have parameter RDW_MODE, default 0: same-address read-during-write; 0 = old data, 1 = new data.
REQ-005 SHALL have parameter CLEAR_ON_RESET, default 1: 1 = reset starts a zeroing sweep; 0 = reset touches control only.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-007 SHALL have port sync_clear, input, 1 bit: reset, synchronous, active-high.
REQ-008 SHALL have port clear_req, input, 1 bit: single-cycle request to zero the whole array.
REQ-009 SHALL have port data, input, DATA_WIDTH: write data.
REQ-010 SHALL have port write_addr, input, ADDR_WIDTH: write address.
REQ-011 SHALL have port we, input, 1 bit: write enable.
REQ-012 SHALL have port lane_we, input, LANES: per-lane write mask; lane i = data[i*LW +: LW].
REQ-013 SHALL have port read_addr, input, ADDR_WIDTH: read address.
REQ-014 SHALL have port re, input, 1 bit: read enable.
REQ-015 SHALL have port q, output, DATA_WIDTH: registered read data.
REQ-016 SHALL have port q_valid, output, 1 bit: q updated by the preceding edge.
REQ-017 SHALL have port busy, output, 1 bit: clear sweep in progress.

Function
REQ-018 FSM states SHALL be IDLE and SWEEP; busy = (state == SWEEP), decoded from the state register.
REQ-019 accept SHALL equal ~busy & ~clear_req; user reads and writes are performed only when accept = 1.
REQ-020 Write: on an edge with we & accept, lanes with lane_we[i] = 1 SHALL take data lane i; other lanes SHALL be unchanged; lane_we = 0 writes nothing.
REQ-021 Read latency SHALL be 1 cycle: an edge with re & accept loads q = mem[read_addr] and sets q_valid = 1 for exactly the next cycle.
REQ-022 Without an accepted read, q SHALL hold its value and q_valid SHALL be 0.
REQ-023 Same-address read and write on one edge: RDW_MODE = 0 SHALL return pre-write contents; RDW_MODE = 1 SHALL return new data on written lanes and old data on unwritten lanes.
REQ-024 IDLE -> SWEEP SHALL occur on an edge with clear_req = 1; the sweep pointer loads 0.
REQ-025 In SWEEP, each edge SHALL write all-zero to mem[ptr] and increment ptr modulo DEPTH.
REQ-026 SWEEP -> IDLE SHALL occur on the edge that zeroes ptr = DEPTH-1; busy is high for exactly DEPTH cycles.
REQ-027 clear_req during SWEEP SHALL be ignored; the sweep does not restart.
REQ-028 we, re, and the addresses SHALL be ignored while busy = 1; q SHALL hold and q_valid SHALL be 0.
REQ-029 After SWEEP, every word SHALL read 0 until written.

Reset
REQ-030 With sync_clear = 1 at an edge, the block SHALL set q = 0, q_valid = 0, ptr = 0, and state = SWEEP if CLEAR_ON_RESET = 1, else IDLE.
REQ-031 sync_clear SHALL override clear_req, we, and re on the same edge.
REQ-032 sync_clear asserted mid-sweep SHALL restart the sweep from ptr = 0 (CLEAR_ON_RESET = 1) or abort it (CLEAR_ON_RESET = 0).
REQ-033 Array contents SHALL be unaffected by reset except through the sweep; with CLEAR_ON_RESET = 0, contents are undefined after power-up.
REQ-034 Held sync_clear SHALL keep busy = 1 (CLEAR_ON_RESET = 1) and ptr = 0; the sweep runs from ptr = 0 to DEPTH-1 once sync_clear drops, with no array write performed while it is high.

Verification
REQ-035 Default params: sync_clear 1 cycle -> busy high 128 cycles; then read of addr 0, 63, 127 -> q = 0, q_valid one cycle after each re.
REQ-036 Write 4'hA at 5, then re at 5 on the next edge -> q = 4'hA and q_valid = 1 one cycle after re; with re low, q holds 4'hA.
REQ-037 LANES = 2, DATA_WIDTH = 8: write 8'h00 at 3, then lane_we = 2'b10 with data 8'hFF -> reads 8'hF0; for RDW on the same edge, RDW_MODE = 0 returns 8'h00 and RDW_MODE = 1 returns 8'hF0.
REQ-038 clear_req with we = 1 to addr 9 (data 4'h7) on the same edge -> write dropped; busy for 128 cycles; addr 9 reads 0; clear_req at sweep cycle 50 -> busy still falls at cycle 128.
REQ-039 sync_clear at sweep cycle 60 -> busy extends to 128 cycles after that edge; addr 100 (prewritten 4'h5) reads 0 afterwards.
REQ-040 CLEAR_ON_RESET = 0: write 4'h3 at 2, pulse sync_clear -> busy stays 0, q = 0, q_valid = 0, and the next read of 2 returns 4'h3.
